// File: rtl/alu_sched_if.sv
// alu_sched_if: request, ALU and response signal bundle for alu_sched.
// Handshake rule for the req_* and resp_* channels: a transfer happens on a
// rising clk edge where valid and ready are both 1. A producer that raises
// valid keeps valid and its payload stable until that edge. alu_valid is a
// one-cycle issue strobe with no ready; alu_c is the ALU's registered result.
interface alu_sched_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_sel;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       alu_valid;
  logic [1:0] alu_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [6:0] alu_c;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [6:0] resp_data;
  logic       resp_err;

  // Scheduler side.
  modport slave (
    input  req_valid, req_sel, req_a, req_b, alu_c, resp_ready,
    output req_ready, alu_valid, alu_sel, alu_a, alu_b,
           resp_valid, resp_id, resp_data, resp_err
  );

  // Requesters, ALU and response consumer side.
  modport master (
    output req_valid, req_sel, req_a, req_b, alu_c, resp_ready,
    input  req_ready, alu_valid, alu_sel, alu_a, alu_b,
           resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of a shared
// pipelined ALU with ALU_LAT cycles of latency. One operation is in flight
// at a time: IDLE grants, ISSUE strobes the ALU, WAIT counts the latency,
// RESP holds the result until the consumer takes it.
// Optional feature macro: ALU_SCHED_DIVZERO_EN -- a granted divide by zero
// bypasses the ALU and answers 7'h7F with resp_err set.
module alu_sched #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_sched_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       alu_valid_q, alu_valid_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [6:0] resp_data_q, resp_data_d;
  logic       resp_err_q, resp_err_d;

  logic       gnt_any;
  logic       gnt_id;
  logic [1:0] gnt_sel;
  logic [3:0] gnt_a;
  logic [3:0] gnt_b;
  logic       gnt_dz;

  // Round-robin pick: the pointed-to requester wins if valid, else the other.
  always_comb begin
    gnt_any = (state_q == IDLE) && !reset && (|bus.req_valid);
    gnt_id  = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
    gnt_sel = gnt_id ? bus.req_sel[3:2] : bus.req_sel[1:0];
    gnt_a   = gnt_id ? bus.req_a[7:4]   : bus.req_a[3:0];
    gnt_b   = gnt_id ? bus.req_b[7:4]   : bus.req_b[3:0];
`ifdef ALU_SCHED_DIVZERO_EN
    gnt_dz  = (gnt_sel == 2'd3) && (gnt_b == 4'd0);
`else
    gnt_dz  = 1'b0;
`endif
  end

  assign bus.req_ready = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alu_valid_d  = 1'b0;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          alu_sel_d = gnt_sel;
          alu_a_d   = gnt_a;
          alu_b_d   = gnt_b;
          resp_id_d = gnt_id;
          ptr_d     = ~gnt_id;
          if (gnt_dz) begin
            // Divide by zero answered locally; the ALU never sees it.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = 7'h7F;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            alu_valid_d = 1'b1;
            resp_err_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 3'd0;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          // alu_c is valid only in this cycle; take it as-is.
          resp_data_d  = bus.alu_c;
          resp_valid_d = 1'b1;
          cnt_d        = 3'd0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= 3'd0;
      alu_valid_q  <= 1'b0;
      alu_sel_q    <= 2'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 7'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alu_valid_q  <= alu_valid_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
`ifdef ALU_SCHED_DIVZERO_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and random checks of alu_sched with ALU_LAT=1
// (dut_a) plus a latency check with ALU_LAT=3 (dut_b). The ALU is modelled
// here; its result is only correct in the cycle it is due.
module tb_alu_sched;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef ALU_SCHED_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sched_if bus_a();
  alu_sched_if bus_b();
  logic [1:0] dbg_a, dbg_b;

  alu_sched #(.ALU_LAT(LAT_A)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a), .dbg_state(dbg_a));
  alu_sched #(.ALU_LAT(LAT_B)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b), .dbg_state(dbg_b));

  // ---------------- ALU reference ----------------
  function automatic logic [6:0] alu_ref(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (sel)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a) * int'(b);
      default: r = (b == 4'd0) ? 127 : int'(a) / int'(b);
    endcase
    return r[6:0];
  endfunction

  // ALU models: result due exactly LAT cycles after the issue cycle.
  logic [6:0] res_a = 7'd0, res_b = 7'd0;
  int cnt_a = 0, cnt_b = 0;
  always @(posedge clk) begin
    if (bus_a.alu_valid === 1'b1) begin
      res_a <= alu_ref(bus_a.alu_sel, bus_a.alu_a, bus_a.alu_b);
      cnt_a <= 1;
    end else if (cnt_a != 0 && cnt_a < 100) cnt_a <= cnt_a + 1;
  end
  always @(posedge clk) begin
    if (bus_b.alu_valid === 1'b1) begin
      res_b <= alu_ref(bus_b.alu_sel, bus_b.alu_a, bus_b.alu_b);
      cnt_b <= 1;
    end else if (cnt_b != 0 && cnt_b < 100) cnt_b <= cnt_b + 1;
  end
  assign bus_a.alu_c = (cnt_a == LAT_A) ? res_a : (res_a ^ 7'h2A);
  assign bus_b.alu_c = (cnt_b == LAT_B) ? res_b : (res_b ^ 7'h2A);

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];   // {id, data} of responses owed
  int gnt_q[$];           // observed grant order
  int cyc = 0, acc_cyc = 0, acc_g = -1, alu_pulses = 0;
  bit busy = 0, cur_dz = 0, ptr = 0;
  logic [1:0] last_sel = 2'd0;
  logic [3:0] last_a = 4'd0, last_b = 4'd0;
  bit last_id = 0, last_err = 0;
  bit pv[2];
  logic [1:0] ps[2];
  logic [3:0] pa[2], pb[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_a();
    bus_a.req_valid = {pv[1], pv[0]};
    bus_a.req_sel   = {ps[1], ps[0]};
    bus_a.req_a     = {pa[1], pa[0]};
    bus_a.req_b     = {pb[1], pb[0]};
  endtask

  task automatic set_op(input int g, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    pv[g] = 1'b1; ps[g] = s; pa[g] = a; pb[g] = b;
  endtask

  task automatic new_op(input int g);
    set_op(g, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // One dut_a cycle: compare against the transaction model, then advance it.
  task automatic step();
    logic [1:0] exp_ready;
    int w, lat;
    bit exp_av, exp_rv;
    #1;
    w = -1;
    exp_ready = 2'b00;
    if (!reset && !busy && (pv[0] || pv[1])) begin
      w = pv[ptr] ? int'(ptr) : int'(!ptr);
      exp_ready = (w == 1) ? 2'b10 : 2'b01;
    end
    chk("req_ready", bus_a.req_ready, exp_ready);
    if (bus_a.req_ready === 2'b01) gnt_q.push_back(0);
    else if (bus_a.req_ready === 2'b10) gnt_q.push_back(1);
    exp_av = busy && !cur_dz && (cyc == acc_cyc + 1);
    chk("alu_valid", bus_a.alu_valid, exp_av);
    if (bus_a.alu_valid === 1'b1) alu_pulses++;
    chk("alu_sel", bus_a.alu_sel, last_sel);
    chk("alu_a", bus_a.alu_a, last_a);
    chk("alu_b", bus_a.alu_b, last_b);
    chk("resp_id", bus_a.resp_id, last_id);
    chk("resp_err", bus_a.resp_err, last_err);
    lat = cur_dz ? 1 : LAT_A + 2;
    exp_rv = busy && (cyc >= acc_cyc + lat);
    chk("resp_valid", bus_a.resp_valid, exp_rv);
    if (exp_rv) chk("resp_payload", {bus_a.resp_id, bus_a.resp_data}, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
    if (reset) begin
      busy = 0; ptr = 0; exp_q.delete();
      last_sel = 2'd0; last_a = 4'd0; last_b = 4'd0; last_id = 0; last_err = 0;
    end else if (exp_rv && bus_a.resp_ready === 1'b1) begin
      busy = 0;
      void'(exp_q.pop_front());
    end else if (w >= 0) begin
      busy = 1; acc_cyc = cyc; ptr = !w[0];
      cur_dz = DZ_EN && (ps[w] == 2'd3) && (pb[w] == 4'd0);
      last_sel = ps[w]; last_a = pa[w]; last_b = pb[w]; last_id = w[0]; last_err = cur_dz;
      exp_q.push_back({w[0], cur_dz ? 7'h7F : alu_ref(ps[w], pa[w], pb[w])});
    end
    acc_g = w;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic reset_a(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before test end");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    set_op(0, 2'd2, 4'd7, 4'd6);
    set_op(1, 2'd1, 4'd9, 4'd2);
    apply_a();
    bus_a.resp_ready = 1'b1;
    bus_b.req_valid = 2'b11; bus_b.req_sel = 4'hF; bus_b.req_a = 8'hFF; bus_b.req_b = 8'hFF;
    bus_b.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset values while requests are pending
    chk("rst_req_ready", bus_a.req_ready, 2'b00);
    chk("rst_alu_valid", bus_a.alu_valid, 1'b0);
    chk("rst_resp_valid", bus_a.resp_valid, 1'b0);
    chk("rst_resp_id", bus_a.resp_id, 1'b0);
    chk("rst_resp_data", bus_a.resp_data, 7'd0);
    chk("rst_resp_err", bus_a.resp_err, 1'b0);
    chk("rst_alu_ops", {bus_a.alu_sel, bus_a.alu_a, bus_a.alu_b}, 10'd0);
    chk("rst_state", dbg_a, 2'd0);
    chk("rst_b_ready", bus_b.req_ready, 2'b00);
    reset = 1'b0;
    pv[0] = 0; pv[1] = 0;
    apply_a();

    // ALU_LAT=3: sub 2-5 on requester 0, response 5 cycles after accept
    bus_b.req_valid = 2'b01; bus_b.req_sel = 4'b0001; bus_b.req_a = 8'h02; bus_b.req_b = 8'h05;
    #1 chk("lat3_ready", bus_b.req_ready, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      bus_b.req_valid = 2'b00;
      chk("lat3_alu_valid", bus_b.alu_valid, (i == 1));
      chk("lat3_resp_valid", bus_b.resp_valid, (i == 5));
    end
    chk("lat3_data", bus_b.resp_data, 7'h7D);
    chk("lat3_id", bus_b.resp_id, 1'b0);
    @(posedge clk); #1;
    chk("lat3_released", bus_b.resp_valid, 1'b0);

    // single add 5+3 on requester 0
    set_op(0, 2'd0, 4'd5, 4'd3);
    apply_a();
    #1 chk("single_ready", bus_a.req_ready, 2'b01);
    step();
    pv[0] = 0; apply_a();
    #1 chk("single_issue", {bus_a.alu_valid, bus_a.alu_a, bus_a.alu_b}, {1'b1, 4'd5, 4'd3});
    step();
    step();
    #1 chk("single_resp", {bus_a.resp_valid, bus_a.resp_id, bus_a.resp_data}, {1'b1, 1'b0, 7'd8});
    step();
    step();

    // contention from reset: grants alternate 0,1,0,1
    reset_a(2);
    set_op(0, 2'd0, 4'd1, 4'd2);
    set_op(1, 2'd2, 4'd15, 4'd15);
    apply_a();
    gnt_q.delete();
    repeat (20) step();
    chk("cont_grants", gnt_q.size(), 5);
    for (int i = 0; i < 4; i++)
      chk("cont_order", (i < gnt_q.size()) ? gnt_q[i] : -1, i % 2);

    // lone requester 1 granted back-to-back
    pv[0] = 0;
    new_op(1);
    apply_a();
    gnt_q.delete();
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc_g >= 0) begin new_op(1); apply_a(); end
    end
    chk("lone_grants", gnt_q.size(), 4);
    foreach (gnt_q[i]) chk("lone_id", gnt_q[i], 1);
    pv[1] = 0; apply_a();
    repeat (4) step();

    // backpressure: response held 5 cycles, no new grant
    set_op(0, 2'd1, 4'd9, 4'd4);
    set_op(1, 2'd0, 4'd3, 4'd3);
    apply_a();
    step();
    chk("bp_accept", acc_g >= 0, 1'b1);
    if (acc_g >= 0) pv[acc_g] = 0;
    apply_a();
    bus_a.resp_ready = 1'b0;
    repeat (LAT_A + 1) step();
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_state", dbg_a, 2'd3);
      step();
    end
    bus_a.resp_ready = 1'b1;
    step();
    #1 chk("bp_idle", dbg_a, 2'd0);
    step();
    pv[0] = 0; pv[1] = 0; apply_a();
    repeat (5) step();

    // divide by zero on requester 1
    set_op(1, 2'd3, 4'd9, 4'd0);
    apply_a();
    alu_pulses = 0;
    step();
    chk("dz_accept", acc_g, 1);
    pv[1] = 0; apply_a();
    repeat (6) step();
    chk("dz_pulses", alu_pulses, DZ_EN ? 0 : 1);

    // reset in WAIT discards the operation and clears the pointer
    set_op(0, 2'd0, 4'd4, 4'd4);
    apply_a();
    step();
    pv[0] = 0; apply_a();
    step();
    #1 chk("rw_in_wait", dbg_a, 2'd2);
    reset_a(1);
    repeat (4) step();
    set_op(0, 2'd0, 4'd1, 4'd1);
    set_op(1, 2'd0, 4'd2, 4'd2);
    apply_a();
    gnt_q.delete();
    step();
    chk("rw_first_grant", (gnt_q.size() > 0) ? gnt_q[0] : -1, 0);
    if (acc_g >= 0) pv[acc_g] = 0;

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus_a.resp_ready = ($urandom_range(0, 3) != 0);
      for (int g = 0; g < 2; g++)
        if (!pv[g] && $urandom_range(0, 1) == 1) new_op(g);
      apply_a();
      step();
      if (acc_g >= 0) pv[acc_g] = 0;
    end
    pv[0] = 0; pv[1] = 0; apply_a();
    bus_a.resp_ready = 1'b1;
    repeat (8) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
